// File: rtl/bram_arb_pkg.sv
// Shared types and default sizing for the two-requester BRAM port arbiter.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } arb_state_e;

    // Requester index: 0 or 1.
    typedef logic owner_t;

    localparam int unsigned DefAw      = 16;
    localparam int unsigned DefDw      = 32;
    localparam int unsigned DefRdLat   = 1;
    localparam int unsigned DefTimeout = 1024;

    function automatic arb_state_e own_state(input owner_t id);
        return id ? StOwn1 : StOwn0;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side beat signals plus the shared BRAM port, bundled for the arbiter.
interface bram_port_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic              req0;
    logic              last0;
    logic [DW/8-1:0]   we0;
    logic [AW-1:0]     addr0;
    logic [DW-1:0]     wdata0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic              last1;
    logic [DW/8-1:0]   we1;
    logic [AW-1:0]     addr1;
    logic [DW-1:0]     wdata1;
    logic              gnt1;
    logic              rvalid1;

    logic [DW-1:0]     rdata;

    logic [AW-1:0]     bram_addr;
    logic              bram_en;
    logic [DW/8-1:0]   bram_we;
    logic [DW-1:0]     bram_wdata;
    logic [DW-1:0]     bram_rdata;

    logic              timeout_flag;

    // Arbiter side.
    modport slave (
        input  req0, last0, we0, addr0, wdata0,
        input  req1, last1, we1, addr1, wdata1,
        input  bram_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output bram_addr, bram_en, bram_we, bram_wdata,
        output timeout_flag
    );

    // Requesters and BRAM side.
    modport master (
        output req0, last0, we0, addr0, wdata0,
        output req1, last1, we1, addr1, wdata1,
        output bram_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  bram_addr, bram_en, bram_we, bram_wdata,
        input  timeout_flag
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register of {valid, owner} tags that tracks reads through the BRAM latency.
module rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_valid,
    input  owner_t push_id,
    output logic   out_valid,
    output owner_t out_id
);

    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] id_q;

    // Advance the tags one stage per cycle; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= {valid_q[Depth-2:0], push_valid};
            id_q    <= {id_q[Depth-2:0], push_id};
        end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_id    = id_q[Depth-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin, burst-locking arbiter sharing one BRAM port between two requesters,
// with a hold timeout and read-data return to the requester that issued the read.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned RD_LAT  = DefRdLat,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input logic                clk,
    input logic                rst_n,
    bram_port_arbiter_if.slave bus
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = $clog2(TIMEOUT);

    arb_state_e    state_q, state_d;
    owner_t        last_owner_q, last_owner_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    owner_t        owner;
    logic          own_req;
    logic          own_last;
    logic          accept;
    logic          push_rd;
    logic [BW-1:0] sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [AW-1:0] bram_addr_q;
    logic          bram_en_q;
    logic [BW-1:0] bram_we_q;
    logic [DW-1:0] bram_wdata_q;

    logic          tag_valid;
    owner_t        tag_id;

    // Pick the owner's beat; the non-owner's inputs never reach the port.
    always_comb begin
        owner     = (state_q == StOwn1);
        own_req   = owner ? bus.req1   : bus.req0;
        own_last  = owner ? bus.last1  : bus.last0;
        sel_we    = owner ? bus.we1    : bus.we0;
        sel_addr  = owner ? bus.addr1  : bus.addr0;
        sel_wdata = owner ? bus.wdata1 : bus.wdata0;
        accept    = (state_q != StIdle) && own_req;
        push_rd   = accept && (sel_we == '0);
    end

    // Grant selection, burst release and forced release on hold timeout.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            StIdle: begin
                hold_cnt_d = '0;
                if (bus.req0 && bus.req1) begin
                    state_d = own_state(~last_owner_q);
                end else if (bus.req0) begin
                    state_d = StOwn0;
                end else if (bus.req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                hold_cnt_d = hold_cnt_q + CW'(1);
                if (accept && own_last) begin
                    state_d      = StIdle;
                    last_owner_d = owner;
                end else if (hold_cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d      = StIdle;
                    last_owner_d = owner;
                    timeout_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Registered BRAM port; address/data hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bram_en_q    <= 1'b0;
            bram_we_q    <= '0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
        end else begin
            bram_en_q <= accept;
            bram_we_q <= accept ? sel_we : '0;
            if (accept) begin
                bram_addr_q  <= sel_addr;
                bram_wdata_q <= sel_wdata;
            end
        end
    end

    rd_tag_pipe #(
        .Depth (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_rd),
        .push_id    (owner),
        .out_valid  (tag_valid),
        .out_id     (tag_id)
    );

    assign bus.gnt0         = (state_q == StOwn0);
    assign bus.gnt1         = (state_q == StOwn1);
    assign bus.rvalid0      = tag_valid && (tag_id == 1'b0);
    assign bus.rvalid1      = tag_valid && (tag_id == 1'b1);
    // The tag emerges exactly when the BRAM output holds the tagged read.
    assign bus.rdata        = tag_valid ? bus.bram_rdata : '0;
    assign bus.bram_addr    = bram_addr_q;
    assign bus.bram_en      = bram_en_q;
    assign bus.bram_we      = bram_we_q;
    assign bus.bram_wdata   = bram_wdata_q;
    assign bus.timeout_flag = timeout_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed vector table, corner-case sequences and
// randomized traffic against a transaction-level reference model.
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int unsigned AW      = 16;
    localparam int unsigned DW      = 32;
    localparam int unsigned BW      = DW / 8;
    localparam int unsigned RD_LAT  = 1;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    bram_port_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .RD_LAT  (RD_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // BRAM model: read-only content derived from the address, RD_LAT cycles after bram_en.
    function automatic logic [DW-1:0] bram_fn(input logic [AW-1:0] a);
        if (a == 16'h00FF) return 32'hCAFEBABE;
        return {a ^ 16'h5A5A, ~a};
    endfunction

    logic [DW-1:0] rd_sr [RD_LAT];
    always @(posedge clk) begin
        if (bus.bram_en) rd_sr[0] <= bram_fn(bus.bram_addr);
        for (int i = 1; i < RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];
    end
    assign bus.bram_rdata = rd_sr[RD_LAT-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic l0, input logic [BW-1:0] w0,
                         input logic [AW-1:0] a0, input logic r1, input logic l1,
                         input logic [BW-1:0] w1, input logic [AW-1:0] a1);
        bus.req0 = r0; bus.last0 = l0; bus.we0 = w0; bus.addr0 = a0;
        bus.wdata0 = {16'hA0A0, a0};
        bus.req1 = r1; bus.last1 = l1; bus.we1 = w1; bus.addr1 = a1;
        bus.wdata1 = {16'hB1B1, a1};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        tick();
        rst_n = 1'b1;
    endtask

    // Directed vectors: inputs applied for one cycle, outputs expected after that edge.
    typedef struct packed {
        logic          rst;
        logic          r0;
        logic          l0;
        logic [BW-1:0] w0;
        logic [AW-1:0] a0;
        logic          r1;
        logic          l1;
        logic [BW-1:0] w1;
        logic [AW-1:0] a1;
        logic          g0;
        logic          g1;
        logic          en;
        logic [BW-1:0] we;
        logic [AW-1:0] addr;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic r0, input logic l0,
                                input logic [BW-1:0] w0, input logic [AW-1:0] a0,
                                input logic r1, input logic l1, input logic [BW-1:0] w1,
                                input logic [AW-1:0] a1, input logic g0, input logic g1,
                                input logic en, input logic [BW-1:0] we,
                                input logic [AW-1:0] addr);
        return '{rst, r0, l0, w0, a0, r1, l1, w1, a1, g0, g1, en, we, addr};
    endfunction

    vec_t vecs [16];

    // Reference model state for the randomized phase.
    typedef struct {
        int            due;
        int            id;
        logic [AW-1:0] addr;
    } rd_t;

    rd_t           rdq [$];
    int            m_owner;
    int            m_last;
    int            m_cycles;
    bit            m_flag;
    logic          e_en;
    logic [BW-1:0] e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            cyc;

    initial begin
        logic          rq [2];
        logic          ls [2];
        logic [BW-1:0] wv [2];
        logic [AW-1:0] av [2];
        logic [DW-1:0] dv [2];
        logic          x_rv0, x_rv1;
        logic [DW-1:0] x_rd;

        // 3-beat write burst from requester 0, then reset and alternating 2-beat bursts.
        vecs[0]  = mk(0, 1,0,4'hF,16'h10, 0,0,4'h0,16'h00, 1,0,0,4'h0,16'h00);
        vecs[1]  = mk(0, 1,0,4'hF,16'h10, 0,0,4'h0,16'h00, 1,0,1,4'hF,16'h10);
        vecs[2]  = mk(0, 1,0,4'hF,16'h11, 0,0,4'h0,16'h00, 1,0,1,4'hF,16'h11);
        vecs[3]  = mk(0, 1,1,4'hF,16'h12, 0,0,4'h0,16'h00, 0,0,1,4'hF,16'h12);
        vecs[4]  = mk(0, 0,0,4'hF,16'h12, 0,0,4'h0,16'h00, 0,0,0,4'h0,16'h12);
        vecs[5]  = mk(1, 0,0,4'h0,16'h00, 0,0,4'h0,16'h00, 0,0,0,4'h0,16'h00);
        vecs[6]  = mk(0, 1,0,4'hF,16'h20, 1,0,4'h3,16'h40, 1,0,0,4'h0,16'h00);
        vecs[7]  = mk(0, 1,0,4'hF,16'h20, 1,0,4'h3,16'h40, 1,0,1,4'hF,16'h20);
        vecs[8]  = mk(0, 1,1,4'hF,16'h21, 1,0,4'h3,16'h40, 0,0,1,4'hF,16'h21);
        vecs[9]  = mk(0, 1,0,4'hF,16'h22, 1,0,4'h3,16'h40, 0,1,0,4'h0,16'h21);
        vecs[10] = mk(0, 1,0,4'hF,16'h22, 1,0,4'h3,16'h40, 0,1,1,4'h3,16'h40);
        vecs[11] = mk(0, 1,0,4'hF,16'h22, 1,1,4'h3,16'h41, 0,0,1,4'h3,16'h41);
        vecs[12] = mk(0, 1,0,4'hF,16'h22, 1,0,4'h3,16'h42, 1,0,0,4'h0,16'h41);
        vecs[13] = mk(0, 1,0,4'hF,16'h22, 1,0,4'h3,16'h42, 1,0,1,4'hF,16'h22);
        vecs[14] = mk(0, 1,1,4'hF,16'h23, 1,0,4'h3,16'h42, 0,0,1,4'hF,16'h23);
        vecs[15] = mk(0, 1,0,4'hF,16'h24, 1,0,4'h3,16'h42, 0,1,0,4'h0,16'h23);

        do_reset();
        chk("reset_gnt0", bus.gnt0, 0);
        chk("reset_gnt1", bus.gnt1, 0);
        chk("reset_en", bus.bram_en, 0);
        chk("reset_flag", bus.timeout_flag, 0);

        for (int i = 0; i < 16; i++) begin
            rst_n = ~vecs[i].rst;
            drive(vecs[i].r0, vecs[i].l0, vecs[i].w0, vecs[i].a0,
                  vecs[i].r1, vecs[i].l1, vecs[i].w1, vecs[i].a1);
            tick();
            chk($sformatf("vec%0d_gnt0", i), bus.gnt0, vecs[i].g0);
            chk($sformatf("vec%0d_gnt1", i), bus.gnt1, vecs[i].g1);
            chk($sformatf("vec%0d_en", i), bus.bram_en, vecs[i].en);
            chk($sformatf("vec%0d_we", i), bus.bram_we, vecs[i].we);
            chk($sformatf("vec%0d_addr", i), bus.bram_addr, vecs[i].addr);
        end

        // Requester 1 single-beat read of 0x00FF.
        do_reset();
        drive(0, 0, '0, '0, 1, 1, '0, 16'h00FF);
        tick();
        chk("rd_gnt1", bus.gnt1, 1);
        tick();
        chk("rd_issue_en", bus.bram_en, 1);
        chk("rd_issue_addr", bus.bram_addr, 16'h00FF);
        chk("rd_issue_we", bus.bram_we, 0);
        chk("rd_early_rvalid1", bus.rvalid1, 0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        tick();
        chk("rd_rvalid1", bus.rvalid1, 1);
        chk("rd_rdata", bus.rdata, 32'hCAFEBABE);
        chk("rd_rvalid0", bus.rvalid0, 0);
        tick();
        chk("rd_rvalid1_pulse", bus.rvalid1, 0);

        // Burst with a bubble beat; requester 1 waits until release.
        do_reset();
        drive(1, 0, 4'hF, 16'h30, 1, 0, 4'hF, 16'h90);
        tick();
        chk("bub_gnt0_first", bus.gnt0, 1);
        chk("bub_gnt1_first", bus.gnt1, 0);
        tick();
        chk("bub_beat0_en", bus.bram_en, 1);
        chk("bub_beat0_addr", bus.bram_addr, 16'h30);
        drive(0, 0, 4'hF, 16'h30, 1, 0, 4'hF, 16'h90);
        tick();
        chk("bub_bubble_en", bus.bram_en, 0);
        chk("bub_bubble_we", bus.bram_we, 0);
        chk("bub_gnt0_held", bus.gnt0, 1);
        chk("bub_gnt1_held", bus.gnt1, 0);
        drive(1, 1, 4'hF, 16'h31, 1, 0, 4'hF, 16'h90);
        tick();
        chk("bub_last_en", bus.bram_en, 1);
        chk("bub_last_addr", bus.bram_addr, 16'h31);
        chk("bub_dead_gnt0", bus.gnt0, 0);
        chk("bub_dead_gnt1", bus.gnt1, 0);
        drive(0, 0, '0, '0, 1, 0, 4'hF, 16'h90);
        tick();
        chk("bub_gnt1_after", bus.gnt1, 1);

        // Hold timeout: requester 0 never sends last.
        do_reset();
        drive(1, 0, 4'hF, 16'h77, 1, 0, 4'h1, 16'h88);
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tick();
            chk($sformatf("to_gnt0_c%0d", k), bus.gnt0, 1);
            chk($sformatf("to_flag_c%0d", k), bus.timeout_flag, 0);
        end
        tick();
        chk("to_release_gnt0", bus.gnt0, 0);
        chk("to_release_gnt1", bus.gnt1, 0);
        chk("to_flag_set", bus.timeout_flag, 1);
        chk("to_final_beat_en", bus.bram_en, 1);
        chk("to_final_beat_addr", bus.bram_addr, 16'h77);
        tick();
        chk("to_gnt1", bus.gnt1, 1);
        chk("to_flag_sticky", bus.timeout_flag, 1);

        // Reset one cycle after a read issues: the read is dropped.
        drive(0, 0, '0, '0, 1, 1, '0, 16'h55);
        tick();
        chk("rst_rd_en", bus.bram_en, 1);
        chk("rst_rd_addr", bus.bram_addr, 16'h55);
        chk("rst_flag_before", bus.timeout_flag, 1);
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        tick();
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_rvalid0", bus.rvalid0, 0);
        chk("rst_rvalid1", bus.rvalid1, 0);
        chk("rst_en", bus.bram_en, 0);
        chk("rst_we", bus.bram_we, 0);
        chk("rst_addr", bus.bram_addr, 0);
        chk("rst_wdata", bus.bram_wdata, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_flag", bus.timeout_flag, 0);
        rst_n = 1'b1;
        drive(1, 0, 4'hF, 16'h01, 1, 0, 4'hF, 16'h02);
        tick();
        chk("rst_late_rvalid1", bus.rvalid1, 0);
        chk("rst_prio_gnt0", bus.gnt0, 1);
        chk("rst_prio_gnt1", bus.gnt1, 0);

        // Randomized traffic against the reference model.
        do_reset();
        rdq.delete();
        m_owner = -1; m_last = 1; m_cycles = 0; m_flag = 0;
        e_en = 0; e_we = '0; e_addr = '0; e_wdata = '0;
        cyc = 0;
        for (int n = 0; n < 600; n++) begin
            for (int r = 0; r < 2; r++) begin
                rq[r] = ($urandom_range(0, 3) != 0);
                ls[r] = ($urandom_range(0, 3) == 0);
                wv[r] = ($urandom_range(0, 1) != 0) ? BW'($urandom_range(1, 15)) : '0;
                av[r] = AW'($urandom);
            end
            drive(rq[0], ls[0], wv[0], av[0], rq[1], ls[1], wv[1], av[1]);
            dv[0] = bus.wdata0;
            dv[1] = bus.wdata1;

            e_en = 1'b0;
            e_we = '0;
            if (m_owner < 0) begin
                if (rq[0] && rq[1]) m_owner = 1 - m_last;
                else if (rq[0]) m_owner = 0;
                else if (rq[1]) m_owner = 1;
                m_cycles = 0;
            end else begin
                m_cycles++;
                if (rq[m_owner]) begin
                    e_en    = 1'b1;
                    e_we    = wv[m_owner];
                    e_addr  = av[m_owner];
                    e_wdata = dv[m_owner];
                    if (wv[m_owner] == '0)
                        rdq.push_back('{cyc + int'(RD_LAT) + 1, m_owner, av[m_owner]});
                end
                if (rq[m_owner] && ls[m_owner]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else if (m_cycles == int'(TIMEOUT)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_flag  = 1'b1;
                end
            end

            tick();
            cyc++;
            x_rv0 = 1'b0;
            x_rv1 = 1'b0;
            x_rd  = '0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                x_rv0 = (rdq[0].id == 0);
                x_rv1 = (rdq[0].id == 1);
                x_rd  = bram_fn(rdq[0].addr);
                void'(rdq.pop_front());
            end
            chk($sformatf("rnd%0d_gnt0", n), bus.gnt0, m_owner == 0);
            chk($sformatf("rnd%0d_gnt1", n), bus.gnt1, m_owner == 1);
            chk($sformatf("rnd%0d_en", n), bus.bram_en, e_en);
            chk($sformatf("rnd%0d_we", n), bus.bram_we, e_we);
            chk($sformatf("rnd%0d_addr", n), bus.bram_addr, e_addr);
            chk($sformatf("rnd%0d_wdata", n), bus.bram_wdata, e_wdata);
            chk($sformatf("rnd%0d_rvalid0", n), bus.rvalid0, x_rv0);
            chk($sformatf("rnd%0d_rvalid1", n), bus.rvalid1, x_rv1);
            if (x_rv0 || x_rv1) chk($sformatf("rnd%0d_rdata", n), bus.rdata, x_rd);
            chk($sformatf("rnd%0d_flag", n), bus.timeout_flag, m_flag);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single PL-side BRAM port (address/enable/write-enable/data) between two PL requesters, e.g. the sequential address generator and a PL-side writer.
- Arbitration is round-robin with burst locking.
- Drives the registered BRAM port signals.
- Routes read data back to the owning requester after the fixed BRAM read latency.

Parameters:
AW, 16, BRAM address width
DW, 32, data width; byte-write-enable width is DW/8
RD_LAT, 1, BRAM read latency in cycles from registered bram_en to valid bram_rdata (1..4)
TIMEOUT, 1024, maximum cycles one requester may hold the grant before forced release (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req0  in  1  requester 0 wants the port / beat valid
last0  in  1  requester 0 final beat of burst
we0  in  DW/8  requester 0 byte write enables; 0 means read
addr0  in  AW  requester 0 beat address
wdata0  in  DW  requester 0 write data
gnt0  out  1  requester 0 owns the port
rvalid0  out  1  read data valid for requester 0
req1, last1, we1, addr1, wdata1, gnt1, rvalid1  same as requester 0, for requester 1
rdata  out  DW  read data, shared by both requesters, qualified by rvalidN
bram_addr  out  AW  BRAM address, registered
bram_en  out  1  BRAM enable, registered
bram_we  out  DW/8  BRAM byte write enables, registered
bram_wdata  out  DW  BRAM write data, registered
bram_rdata  in  DW  BRAM read data
timeout_flag  out  1  sticky: a forced release has occurred

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - gnt0/1, rvalid0/1, bram_en, bram_we, bram_addr, bram_wdata, rdata and timeout_flag all go to 0.
  - State goes to IDLE; last_owner goes to 1, so requester 0 wins the first tie.
  - The read-tag pipe is flushed; a read in flight when reset is asserted never produces rvalid.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - If only one req is high, go to that OWNn; gntn rises the next cycle.
  - If both are high, grant the requester that is not last_owner.
  - If neither is high, stay in IDLE.
- OWNn:
  - gntn=1 for the whole state; the other gnt=0.
  - A beat is accepted in a cycle where reqn=1.
  - On an accepted beat, the next cycle gives bram_en=1, bram_addr=addrn, bram_we=wen, bram_wdata=wdatan. This is a 1-cycle issue latency.
  - In a cycle with reqn=0 the owner keeps the grant (burst lock) and bram_en=0, bram_we=0 the next cycle.
- Release:
  - An accepted beat with lastn=1 sends the state to IDLE and sets last_owner=n.
  - gnt drops the cycle after the last beat is accepted, so there is one dead cycle between bursts.
  - A single-beat burst (req and last together on the first granted cycle) is legal.
- Timeout:
  - The hold counter resets on entry to OWNn and increments every cycle in OWNn.
  - When the counter reaches TIMEOUT-1 without a last beat, the state is forced to IDLE, last_owner=n and timeout_flag=1 (sticky until reset).
  - A beat accepted in that final cycle is still issued.
- Reads:
  - A beat with wen==0 pushes {valid, owner id} into an RD_LAT+1 deep tag pipe.
  - RD_LAT+1 cycles after acceptance (RD_LAT after bram_en), rdata is loaded from bram_rdata and rvalidn=1 for exactly 1 cycle for the tagged owner.
  - Write beats push an invalid tag.
  - Reads from a previous owner still complete after a grant change; there is no ordering stall.
- Signals ignored by the arbiter:
  - req, last, we, addr and wdata of the requester that does not own the port.
  - A last input without a matching req.
- Address is passed through unmodified. There is no wrap logic; wrap is the requester's job.

Decomposition:
- Package bram_arb_pkg:
  - State enum (IDLE/OWN0/OWN1).
  - Owner-id type (1 bit).
  - Default AW/DW/RD_LAT/TIMEOUT constants.
- Sub-module rd_tag_pipe:
  - Parameterised depth RD_LAT+1 shift register of {valid, id}, synchronous active-low clear.
  - Its output drives rvalid0/1 and the rdata load.

Test Plan:
- Reset, then req0=1 with a 3-beat write burst (addr 0x0010..0x0012, last on the 3rd beat):
  - gnt0 rises on cycle 1 after req.
  - bram_en=1 for 3 consecutive cycles with bram_we=0xF and addr 0x0010, 0x0011, 0x0012.
  - gnt0=0 the cycle after the last beat.
- req0 and req1 both held high continuously, each issuing 2-beat bursts:
  - grants alternate 0, 1, 0, 1 with exactly one dead cycle between bursts.
  - After reset, requester 0 is granted first.
- Requester 1 read of addr 0x00FF with RD_LAT=1, BRAM model returning 0xCAFEBABE:
  - rvalid1=1 and rdata=0xCAFEBABE exactly 2 cycles after acceptance.
  - rvalid0 stays 0.
- Owner 0 holds the grant with req0 toggling 1,0,1 and last on the third cycle:
  - the bubble beat gives bram_en=0.
  - gnt0 is held through the bubble.
  - req1 is not granted until the burst releases.
- TIMEOUT=8, req0 held high with last0=0 and req1 high:
  - forced release after 8 cycles of ownership.
  - timeout_flag=1 and stays high.
  - gnt1 rises after one dead cycle.
- rst_n pulsed low for 1 cycle, 1 cycle after a read beat is issued:
  - no rvalid appears.
  - all outputs are 0 on the cycle after reset.
  - arbitration restarts with requester 0 priority.
